// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures a slow, asynchronous square wave (e.g. a divider-generated pacing
//   clock) in clkIn cycles. It reports the full period and the most recent high
//   time, and flags an input that has stopped toggling.
//
// Ports
//   clkIn        system clock, all logic on its rising edge
//   rst          asynchronous, active-high reset
//   sigIn        slow signal under measurement (asynchronous to clkIn)
//   period       clkIn cycles between the last two detected rises of sigIn
//   highTime     clkIn cycles sigIn was high in the last completed high phase
//   periodValid  one-cycle pulse whenever period is updated
//   locked       a full period has been measured and no stall has occurred since
//   stalled      set on timeout, cleared by the next period measurement
module clk_period_meter #(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] TIMEOUT = 26'd20000000
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic             sigIn,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic             periodValid,
  output logic             locked,
  output logic             stalled
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_M1   = TIMEOUT - 1'b1;

  state_t           state, stateNxt;
  logic [2:0]       syncPipe;          // [0]=s1, [1]=s2, [2]=s3 (edge register)
  logic [CNT_W-1:0] perCnt, hiCnt;
  logic             s2, s3, rise, fall, toHit;
  logic             loadPer, setStall;

  assign s2   = syncPipe[1];
  assign s3   = syncPipe[2];
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // A rise on the timeout edge takes priority, so the timeout is qualified by !rise.
  assign toHit = ~rise & (state != IDLE) & (perCnt == TO_M1);

  assign locked = (state == LOCKED);

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      syncPipe <= '0;
      state    <= IDLE;
    end else begin
      syncPipe <= {syncPipe[1:0], sigIn};
      state    <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    loadPer  = 1'b0;
    setStall = 1'b0;
    unique case (state)
      IDLE:   if (rise) stateNxt = ARMED;
      ARMED,
      LOCKED: begin
        if (rise) begin
          stateNxt = LOCKED;
          loadPer  = 1'b1;
        end else if (toHit) begin
          stateNxt = IDLE;
          setStall = 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Counters: both restart at 1 on a rise so the captured value is the
  // number of clkIn cycles spanned. Saturation keeps a dead input from wrapping.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      perCnt <= '0;
      hiCnt  <= '0;
    end else begin
      if (rise)                  perCnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (perCnt != CNT_MAX) perCnt <= perCnt + 1'b1;

      if (rise)                       hiCnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (s3 && hiCnt != CNT_MAX) hiCnt <= hiCnt + 1'b1;
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      period      <= '0;
      highTime    <= '0;
      periodValid <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      periodValid <= loadPer;
      if (loadPer) period   <= perCnt;
      if (fall)    highTime <= hiCnt;
      if (setStall)     stalled <= 1'b1;
      else if (loadPer) stalled <= 1'b0;
    end
  end

endmodule
